// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: one digit per clk_1k rise, BCD value latched once per frame,
// with leading-zero blanking, per-digit decimal point and per-digit blink.
module seg_scan #(
    parameter int DIGITS      = 8,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_1k,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic                s1, s2, s3;
    logic                tick, wrap;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] frame;
    logic [CNT_W-1:0]    blink_cnt;
    logic                phase;
    logic [DIGITS:0]     upper_zero;
    logic [3:0]          nibble;
    logic                blank;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;
    logic                dp_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // clk_1k is asynchronous data: synchronise, then take its rising edge as a one-clk tick.
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_1k;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            frame       <= '0;
            frame_start <= 1'b0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
                if (wrap) frame <= value;
                if (blink_cnt == CNT_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // upper_zero[k]: frame nibbles k..DIGITS-1 are all zero.
    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        upper_zero = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (frame[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        nibble   = frame[{idx, 2'b00} +: 4];
        blank    = (lz_blank && (idx != '0) && upper_zero[idx]) ||
                   (phase && blink_mask[idx]);
        an_next  = '1;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!blank) begin
            an_next  = ~(DIGITS'(1) << idx);
            seg_next = decode(nibble);
            dp_next  = ~dp_mask[idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: directed literal checks plus randomized clk_1k/value/mask stimulus
// compared every cycle against an arithmetic model of the display rules.
module tb_seg_scan;

    localparam int DIGITS = 8;
    localparam int BT     = 4;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_1k = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic        lz_blank = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;

    seg_scan #(.DIGITS(DIGITS), .BLINK_TICKS(BT)) dut (
        .clk(clk), .rst(rst), .clk_1k(clk_1k), .value(value), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp),
        .frame_start(frame_start));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a clk_1k rise seen at edge n advances the scan at edge n+2; the outputs after
    // an edge show the digit selected before that edge.
    int          m_idx, m_cnt, edge_n;
    bit          m_phase, prev_h;
    logic [31:0] m_frame;
    int          adv_q[$];
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    always @(posedge clk or negedge rst) begin
        bit blank;
        int nib;
        if (!rst) begin
            m_idx = 0; m_cnt = 0; m_phase = 0; m_frame = '0; prev_h = 0; edge_n = 0;
            adv_q.delete();
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            nib   = int'((m_frame >> (4 * m_idx)) & 32'hF);
            blank = (lz_blank && m_idx > 0 && (m_frame >> (4 * m_idx)) == 0) ||
                    (m_phase && blink_mask[m_idx]);
            if (blank) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = ~(8'(1) << m_idx); e_seg = SEG_TAB[nib]; e_dp = ~dp_mask[m_idx];
            end
            e_fs = 1'b0;
            if (adv_q.size() > 0 && adv_q[0] == edge_n) begin
                void'(adv_q.pop_front());
                if (m_idx == DIGITS - 1) begin
                    m_idx = 0; m_frame = value; e_fs = 1'b1;
                end else begin
                    m_idx++;
                end
                m_cnt++;
                if (m_cnt == BT) begin
                    m_cnt = 0; m_phase = !m_phase;
                end
            end
            if (clk_1k && !prev_h) adv_q.push_back(edge_n + 2);
            prev_h = clk_1k;
            edge_n++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst === 1'b1) begin
            check("model_an", an, e_an);
            check("model_seg", seg, e_seg);
            check("model_dp", dp, e_dp);
            check("model_frame_start", frame_start, e_fs);
        end
        if (frame_start === 1'b1) fs_cnt++;
    end

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk_1k = 1'b1;
            repeat (4) @(negedge clk);
            clk_1k = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        int fs0, hold;
        // T1 reset
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fs", frame_start, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel_an", an, 8'hFE);
        check("rel_seg", seg, 7'h40);

        // T3 frame latch and leading-zero blanking
        lz_blank = 1'b1; value = 32'h0000_1234;
        fs0 = fs_cnt;
        do_tick(8);
        check("fs_once", fs_cnt, fs0 + 1);
        check("d0_seg", seg, 7'h19);
        check("d0_an", an, 8'hFE);
        do_tick(3);
        check("d3_seg", seg, 7'h79);
        check("d3_an", an, 8'hF7);
        do_tick(1);
        check("d4_lz_an", an, 8'hFF);
        value = 32'h8888_8888;
        do_tick(1);
        check("d5_old_frame_an", an, 8'hFF);
        do_tick(3);
        check("new_frame_seg", seg, 7'h00);
        check("fs_twice", fs_cnt, fs0 + 2);

        // T4 nibble A and decimal point
        value = 32'h0000_0A00; lz_blank = 1'b0; dp_mask = 8'h04;
        do_tick(8);
        check("a_d0_seg", seg, 7'h40);
        check("a_d0_dp", dp, 1'b1);
        do_tick(2);
        check("a_d2_an", an, 8'hFB);
        check("a_d2_seg", seg, 7'h3F);
        check("a_d2_dp", dp, 1'b0);
        do_tick(1);
        check("a_d3_dp", dp, 1'b1);

        // T2 clk_1k held high gives a single advance
        @(negedge clk) clk_1k = 1'b1;
        repeat (500) @(negedge clk);
        check("hold_an", an, 8'hEF);
        clk_1k = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_low_an", an, 8'hEF);

        // T5 blink with a fresh phase
        rst = 1'b0; value = '0; dp_mask = '0; blink_mask = 8'hFF;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("blk_d0_shown", an, 8'hFE);
        do_tick(1);
        check("blk_d1_shown", an, 8'hFD);
        do_tick(3);
        check("blk_d4_dark", an, 8'hFF);
        do_tick(4);
        check("blk_d0_again", an, 8'hFE);
        blink_mask = 8'h01;
        do_tick(4);
        check("blk_d4_unmasked", an, 8'hEF);

        // T6 mid-scan reset at idx 5
        blink_mask = '0;
        do_tick(1);
        check("pre_rst_an", an, 8'hDF);
        @(negedge clk) rst = 1'b0;
        #1;
        check("mid_rst_an", an, 8'hFF);
        check("mid_rst_seg", seg, 7'h7F);
        value = 32'h0000_0007;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rerel_an", an, 8'hFE);
        check("rerel_seg", seg, 7'h40);
        do_tick(8);
        check("relatch_seg", seg, 7'h78);

        // Randomized run against the model
        hold = 1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (--hold == 0) begin
                clk_1k = ~clk_1k;
                hold = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 60) == 0) begin
                for (int d = 0; d < DIGITS; d++)
                    value[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            if ($urandom_range(0, 30) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 30) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(0, 40) == 0) lz_blank = ~lz_blank;
            if (cyc == 3000) begin
                rst = 1'b0;
                @(negedge clk) rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
